// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the multi-cycle multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_e;

    // Wide enough for any supported WIDTH; the top slices what it needs.
    localparam int MAX_WIDTH = 128;
    localparam logic [MAX_WIDTH-1:0] DBZ_LO_ONES = '1;

    function automatic logic op_is_div(input logic [1:0] o);
        return o[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] o);
        return ~o[0];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath: conditional add (multiply)
// or trial subtract with restore (divide) on a WIDTH+1-bit ripple adder.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] opnd_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH:0]   x;
    logic [WIDTH:0]   y;
    logic [WIDTH:0]   sum;
    logic [WIDTH+1:0] c;
    logic [WIDTH:0]   shifted;

    assign shifted = {acc_i, lo_i[WIDTH-1]};

    always_comb begin
        if (is_div) begin
            x = shifted;
            y = ~{1'b0, opnd_i};
        end else begin
            x = {1'b0, acc_i};
            y = lo_i[0] ? {1'b0, opnd_i} : '0;
        end
    end

    // carry-in of 1 turns the inverted divisor into a subtract
    assign c[0] = is_div;

    for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
        assign sum[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    always_comb begin
        acc_o = acc_i;
        lo_o  = lo_i;
        if (is_div) begin
            // carry out set means no borrow: shifted remainder >= divisor
            if (c[WIDTH+1]) begin
                acc_o = sum[WIDTH-1:0];
                lo_o  = {lo_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = shifted[WIDTH-1:0];
                lo_o  = {lo_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_o = sum[WIDTH:1];
            lo_o  = {sum[0], lo_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// MULT/MULTU/DIV/DIVU unit holding HI/LO; start/busy/done handshake.
// Define MULDIV_MTHILO_EN to add the MTHI/MTLO write ports (hi_we, lo_we, wdata).
//
// state | meaning
// IDLE  | waiting for start; hi/lo hold (or take MTHI/MTLO writes)
// RUN   | one multiply/divide iteration per cycle, counter counts down
// FIX   | apply result signs (or divide-by-zero values), write hi/lo
// DONE  | done pulse, busy still high
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef MULDIV_MTHILO_EN
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
`endif
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    import muldiv_pkg::*;

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   lo_w_q, lo_w_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               a_sgn_q, a_sgn_d;
    logic               b_sgn_q, b_sgn_d;
    logic               dbz_pend_q, dbz_pend_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               a_neg, b_neg, b_zero;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH-1:0]   step_acc, step_lo;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic               neg_lo, neg_hi;

    assign a_neg  = op_is_signed(op) & a[WIDTH-1];
    assign b_neg  = op_is_signed(op) & b[WIDTH-1];
    assign b_zero = (b == '0);
    assign mag_a  = a_neg ? (~a + WIDTH'(1)) : a;
    assign mag_b  = b_neg ? (~b + WIDTH'(1)) : b;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div (op_is_div(op_q)),
        .acc_i  (acc_q),
        .lo_i   (lo_w_q),
        .opnd_i (opnd_q),
        .acc_o  (step_acc),
        .lo_o   (step_lo)
    );

    // Sign fix-up works on magnitudes, so the most negative dividend over -1
    // naturally wraps back to itself in the quotient.
    assign neg_lo   = op_is_signed(op_q) & (a_sgn_q ^ b_sgn_q);
    assign neg_hi   = op_is_signed(op_q) & a_sgn_q;
    assign prod     = {acc_q, lo_w_q};
    assign prod_fix = neg_lo ? (~prod + (2*WIDTH)'(1)) : prod;
    assign quo_fix  = neg_lo ? (~lo_w_q + WIDTH'(1)) : lo_w_q;
    assign rem_fix  = neg_hi ? (~acc_q + WIDTH'(1)) : acc_q;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        lo_w_d     = lo_w_q;
        opnd_d     = opnd_q;
        a_sgn_d    = a_sgn_q;
        b_sgn_d    = b_sgn_q;
        dbz_pend_d = dbz_pend_q;
        dbz_d      = dbz_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        unique case (state_q)
            IDLE: begin
`ifdef MULDIV_MTHILO_EN
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
`endif
                if (start) begin
                    op_d       = op;
                    a_sgn_d    = a[WIDTH-1];
                    b_sgn_d    = b[WIDTH-1];
                    cnt_d      = CNT_W'(WIDTH);
                    acc_d      = '0;
                    dbz_d      = 1'b0;
                    dbz_pend_d = 1'b0;
                    state_d    = RUN;
                    if (op_is_div(op)) begin
                        opnd_d = mag_b;
                        lo_w_d = mag_a;
                        if (b_zero) begin
                            // keep raw dividend; it becomes HI
                            lo_w_d     = a;
                            dbz_pend_d = 1'b1;
                            state_d    = FIX;
                        end
                    end else begin
                        opnd_d = mag_a;
                        lo_w_d = mag_b;
                    end
                end
            end
            RUN: begin
                acc_d  = step_acc;
                lo_w_d = step_lo;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = FIX;
            end
            FIX: begin
                state_d = DONE;
                if (dbz_pend_q) begin
                    hi_d  = lo_w_q;
                    lo_d  = DBZ_LO_ONES[WIDTH-1:0];
                    dbz_d = 1'b1;
                end else if (op_is_div(op_q)) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= OP_MULT;
            cnt_q      <= '0;
            acc_q      <= '0;
            lo_w_q     <= '0;
            opnd_q     <= '0;
            a_sgn_q    <= 1'b0;
            b_sgn_q    <= 1'b0;
            dbz_pend_q <= 1'b0;
            dbz_q      <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            lo_w_q     <= lo_w_d;
            opnd_q     <= opnd_d;
            a_sgn_q    <= a_sgn_d;
            b_sgn_q    <= b_sgn_d;
            dbz_pend_q <= dbz_pend_d;
            dbz_q      <= dbz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
